// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall sequencer.
package hazard_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_J   = 2'd2;
    localparam logic [1:0] PCSRC_JR  = 2'd3;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter used for stall/redirect statistics.
module hazard_perf_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: load-use and HI/LO stalls, MEM redirects, mult/div abort.
// Optional stall/redirect counters are built only when HAZARD_PERF_CNT_EN is defined.
//
// state      | meaning
// ST_RUN     | no mult/div occupying the HI/LO path
// ST_MD_BUSY | mult/div in flight, cnt counts down to its last cycle
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_uses_rs,
    input  logic             ID_uses_rt,
    input  logic             ID_muldiv,
    input  logic             ID_reads_hilo,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rt,
    input  logic [1:0]       MEM_PCSrc,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             MulDivAbort,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic redirect, load_use, md_stall, stall, abort, issue;

    assign redirect = (MEM_PCSrc != PCSRC_SEQ);
    assign load_use = EX_MemRead && (EX_rt != ZERO_REG) &&
                      ((ID_uses_rs && (ID_rs == EX_rt)) || (ID_uses_rt && (ID_rt == EX_rt)));
    // The last busy cycle (cnt == 0) releases the HI/LO consumer.
    assign md_stall = (state_q == ST_MD_BUSY) && (cnt_q != 4'd0) && (ID_reads_hilo || ID_muldiv);
    assign stall    = !redirect && (load_use || md_stall);
    assign abort    = redirect && (state_q == ST_MD_BUSY) && (cnt_q == CNT_LOAD);
    assign issue    = !redirect && !stall && ID_muldiv &&
                      ((state_q == ST_RUN) || (cnt_q == 4'd0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (issue) begin
            state_d = ST_MD_BUSY;
            cnt_d   = CNT_LOAD;
        end else if (state_q == ST_MD_BUSY) begin
            if (abort || (cnt_q == 4'd0)) begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        EXMEMFlush  = 1'b0;
        MulDivAbort = 1'b0;
        if (!Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (redirect) begin
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            EXMEMFlush  = 1'b1;
            MulDivAbort = abort;
        end else if (stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    assign Busy = (state_q == ST_MD_BUSY);

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .inc_i   (Reset && !PCWrite),
        .count_o (StallCount)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk_i   (Clk),
        .rst_n_i (Reset),
        .inc_i   (Reset && redirect),
        .count_o (FlushCount)
    );
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
